if_fetch_stage: RTL and testbench

Instruction-fetch stage of the 5-stage MIPS pipeline. It holds the PC, selects the next PC, fetches from a combinational instruction memory port, and owns the IF/ID pipeline register. It consumes the hazard detection unit's outputs: PC_Write, IF_ID_Write, PC_Mux_select and IF_ID_Mux_select. It also keeps stall and flush performance counters and a sticky flag for misaligned control-flow targets.

---
 rtl/if_fetch_stage.sv | 130 +++++++++++++
 tb/tb_if_fetch_stage.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/if_fetch_stage.sv
// if_fetch_stage
// Instruction-fetch stage of a 5-stage MIPS pipeline. It holds the PC,
// selects the next PC from the hazard unit's mux select, presents the PC to a
// combinational instruction memory, and owns the IF/ID pipeline register.
// It also keeps saturating stall/flush counters and a sticky misalignment flag.
//
// Ports
//   clk               pipeline clock, rising edge
//   rst               synchronous active-high reset
//   PC_Write          1 = PC may update, 0 = PC holds
//   IF_ID_Write       1 = IF/ID may update, 0 = IF/ID holds
//   PC_Mux_select     00 PC+4, 01 branch, 10 jump, 11 jump-register
//   IF_ID_Mux_select  1 = load a bubble into IF/ID
//   branch_target     branch target from ID
//   jump_target       J/JAL target from ID
//   jumpreg_target    JR/JALR target from ID
//   imem_addr         instruction memory address (= PC)
//   imem_rdata        instruction word at imem_addr (same cycle)
//   IF_ID_Instr       registered instruction for ID
//   IF_ID_PC_plus4    registered PC+4 of that instruction
//   IF_ID_Valid       1 = real fetched instruction, 0 = bubble/reset
//   misalign_err      sticky: a selected redirect target had bits [1:0] != 0
//   stall_cnt         cycles with PC_Write=0, saturating
//   flush_cnt         cycles a bubble was written into IF/ID, saturating

module if_fetch_stage #(
  parameter int unsigned          ADDR_W    = 32,
  parameter logic [ADDR_W-1:0]    RESET_PC  = '0,
  parameter logic [31:0]          NOP_INSTR = 32'h0000_0000,
  parameter int unsigned          CNT_W     = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              PC_Write,
  input  logic              IF_ID_Write,
  input  logic [1:0]        PC_Mux_select,
  input  logic              IF_ID_Mux_select,
  input  logic [ADDR_W-1:0] branch_target,
  input  logic [ADDR_W-1:0] jump_target,
  input  logic [ADDR_W-1:0] jumpreg_target,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [31:0]       imem_rdata,
  output logic [31:0]       IF_ID_Instr,
  output logic [ADDR_W-1:0] IF_ID_PC_plus4,
  output logic              IF_ID_Valid,
  output logic              misalign_err,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] pc_plus4;
  logic [ADDR_W-1:0] raw_target;
  logic [ADDR_W-1:0] next_pc;
  logic              redirect;
  logic              target_misaligned;
  logic              flush_write;

  assign imem_addr = pc;
  assign pc_plus4  = pc + ADDR_W'(4);

  // Raw (unmasked) redirect target; only meaningful when select != 00.
  always_comb begin
    raw_target = pc_plus4;
    case (PC_Mux_select)
      2'b01:   raw_target = branch_target;
      2'b10:   raw_target = jump_target;
      2'b11:   raw_target = jumpreg_target;
      default: raw_target = pc_plus4;
    endcase
  end

  assign redirect          = (PC_Mux_select != 2'b00);
  assign target_misaligned = redirect && (raw_target[1:0] != 2'b00);

  // Redirect targets are word-aligned before loading; PC+4 is aligned already
  // because PC only ever receives aligned values.
  assign next_pc     = redirect ? {raw_target[ADDR_W-1:2], 2'b00} : pc_plus4;
  assign flush_write = IF_ID_Write && IF_ID_Mux_select;

  always_ff @(posedge clk) begin
    if (rst) begin
      pc <= RESET_PC;
    end else if (PC_Write) begin
      pc <= next_pc;
    end
  end

  // A stall (IF_ID_Write=0) takes priority over a flush: the flush select is
  // stale while the hazard unit is stalling.
  always_ff @(posedge clk) begin
    if (rst) begin
      IF_ID_Instr    <= NOP_INSTR;
      IF_ID_PC_plus4 <= '0;
      IF_ID_Valid    <= 1'b0;
    end else if (IF_ID_Write) begin
      IF_ID_PC_plus4 <= pc_plus4;
      if (IF_ID_Mux_select) begin
        IF_ID_Instr <= NOP_INSTR;
        IF_ID_Valid <= 1'b0;
      end else begin
        IF_ID_Instr <= imem_rdata;
        IF_ID_Valid <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      misalign_err <= 1'b0;
    end else if (PC_Write && target_misaligned) begin
      misalign_err <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (!PC_Write && (stall_cnt != '1)) begin
        stall_cnt <= stall_cnt + CNT_W'(1);
      end
      if (flush_write && (flush_cnt != '1)) begin
        flush_cnt <= flush_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_if_fetch_stage.sv
module tb_if_fetch_stage;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned CNT_W  = 8;
  localparam logic [31:0] NOP    = 32'h0000_0000;
  localparam int          CNT_MAX = (1 << CNT_W) - 1;

  logic              clk = 1'b0;
  logic              rst;
  logic              PC_Write;
  logic              IF_ID_Write;
  logic [1:0]        PC_Mux_select;
  logic              IF_ID_Mux_select;
  logic [31:0]       branch_target;
  logic [31:0]       jump_target;
  logic [31:0]       jumpreg_target;
  logic [31:0]       imem_addr;
  logic [31:0]       imem_rdata;
  logic [31:0]       IF_ID_Instr;
  logic [31:0]       IF_ID_PC_plus4;
  logic              IF_ID_Valid;
  logic              misalign_err;
  logic [CNT_W-1:0]  stall_cnt;
  logic [CNT_W-1:0]  flush_cnt;

  if_fetch_stage #(
    .ADDR_W   (ADDR_W),
    .RESET_PC (32'h0000_0000),
    .NOP_INSTR(NOP),
    .CNT_W    (CNT_W)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .PC_Write        (PC_Write),
    .IF_ID_Write     (IF_ID_Write),
    .PC_Mux_select   (PC_Mux_select),
    .IF_ID_Mux_select(IF_ID_Mux_select),
    .branch_target   (branch_target),
    .jump_target     (jump_target),
    .jumpreg_target  (jumpreg_target),
    .imem_addr       (imem_addr),
    .imem_rdata      (imem_rdata),
    .IF_ID_Instr     (IF_ID_Instr),
    .IF_ID_PC_plus4  (IF_ID_PC_plus4),
    .IF_ID_Valid     (IF_ID_Valid),
    .misalign_err    (misalign_err),
    .stall_cnt       (stall_cnt),
    .flush_cnt       (flush_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return 32'h1000_0000 | a;
  endfunction

  assign imem_rdata = mem_word(imem_addr);

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: architectural state as plain integers.
  longint m_pc;
  longint m_instr, m_pc4;
  bit     m_valid, m_mis;
  int     m_stall, m_flush;

  task automatic model_edge();
    longint tgt, nxt, p4;
    p4 = (m_pc + 4) % (64'd1 << 32);
    case (PC_Mux_select)
      2'd1:    tgt = branch_target;
      2'd2:    tgt = jump_target;
      2'd3:    tgt = jumpreg_target;
      default: tgt = p4;
    endcase
    nxt = (PC_Mux_select == 2'd0) ? p4 : (tgt / 4) * 4;
    if (rst) begin
      m_pc = 0; m_instr = NOP; m_pc4 = 0; m_valid = 0; m_mis = 0;
      m_stall = 0; m_flush = 0;
    end else begin
      if (IF_ID_Write) begin
        m_pc4 = p4;
        if (IF_ID_Mux_select) begin
          m_instr = NOP; m_valid = 0;
          if (m_flush < CNT_MAX) m_flush++;
        end else begin
          m_instr = mem_word(32'(m_pc)); m_valid = 1;
        end
      end
      if (PC_Write) begin
        if (PC_Mux_select != 0 && (tgt % 4) != 0) m_mis = 1;
        m_pc = nxt;
      end else if (m_stall < CNT_MAX) begin
        m_stall++;
      end
    end
  endtask

  task automatic check_all();
    check("pc",        imem_addr,      m_pc);
    check("instr",     IF_ID_Instr,    m_instr);
    check("pc4",       IF_ID_PC_plus4, m_pc4);
    check("valid",     IF_ID_Valid,    m_valid);
    check("misalign",  misalign_err,   m_mis);
    check("stall_cnt", stall_cnt,      m_stall);
    check("flush_cnt", flush_cnt,      m_flush);
  endtask

  task automatic drive(input logic r, input logic pw, input logic iw, input logic [1:0] sel,
                       input logic fl, input logic [31:0] bt, input logic [31:0] jt,
                       input logic [31:0] jrt);
    rst = r; PC_Write = pw; IF_ID_Write = iw; PC_Mux_select = sel;
    IF_ID_Mux_select = fl; branch_target = bt; jump_target = jt; jumpreg_target = jrt;
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_all();
  endtask

  task automatic seq(input int n);
    for (int i = 0; i < n; i++) begin
      drive(0, 1, 1, 2'b00, 0, 32'h0, 32'h0, 32'h0);
      cycle();
    end
  endtask

  initial begin
    m_pc = 0; m_instr = 0; m_pc4 = 0; m_valid = 0; m_mis = 0; m_stall = 0; m_flush = 0;
    drive(1, 1, 1, 2'b00, 0, 32'h0, 32'h0, 32'h0);
    cycle();
    cycle();
    check("rst_valid", IF_ID_Valid, 1'b0);

    // Sequential run from reset.
    seq(1);
    check("first_instr", IF_ID_Instr, 32'h1000_0000);
    check("first_pc4",   IF_ID_PC_plus4, 32'h4);
    check("first_valid", IF_ID_Valid, 1'b1);
    seq(7);
    check("at_0x20", imem_addr, 32'h20);

    // Load-use stall with stale flush and select.
    for (int i = 0; i < 2; i++) begin
      drive(0, 0, 0, 2'b01, 1, 32'h0000_0500, 32'h0, 32'h0);
      cycle();
    end
    check("stall_pc",    imem_addr, 32'h20);
    check("stall_cnt2",  stall_cnt, 8'd2);
    check("stall_flush", flush_cnt, 8'd0);
    check("stall_valid", IF_ID_Valid, 1'b1);

    seq(8);
    check("at_0x40", imem_addr, 32'h40);
    drive(0, 1, 1, 2'b01, 1, 32'h0000_0100, 32'h0, 32'h0);
    cycle();
    check("br_pc",    imem_addr, 32'h100);
    check("br_instr", IF_ID_Instr, NOP);
    check("br_valid", IF_ID_Valid, 1'b0);
    check("br_flush", flush_cnt, 8'd1);
    seq(1);
    check("br_tgt_instr", IF_ID_Instr, 32'h1000_0100);
    check("br_tgt_valid", IF_ID_Valid, 1'b1);

    // Misaligned jump-register target.
    drive(0, 1, 1, 2'b11, 1, 32'h0, 32'h0, 32'h0000_0206);
    cycle();
    check("jr_pc",  imem_addr, 32'h204);
    check("jr_mis", misalign_err, 1'b1);
    seq(10);
    check("mis_sticky", misalign_err, 1'b1);

    // PC wrap.
    drive(0, 1, 1, 2'b10, 1, 32'h0, 32'hFFFF_FFFC, 32'h0);
    cycle();
    check("wrap_pre", imem_addr, 32'hFFFF_FFFC);
    seq(1);
    check("wrap_pc",  imem_addr, 32'h0);
    check("wrap_pc4", IF_ID_PC_plus4, 32'h0);

    // Counter saturation.
    for (int i = 0; i < CNT_MAX + 20; i++) begin
      drive(0, 0, 0, 2'b00, 0, 32'h0, 32'h0, 32'h0);
      cycle();
    end
    check("stall_sat", stall_cnt, CNT_MAX);
    for (int i = 0; i < CNT_MAX + 20; i++) begin
      drive(0, 1, 1, 2'b00, 1, 32'h0, 32'h0, 32'h0);
      cycle();
    end
    check("flush_sat", flush_cnt, CNT_MAX);

    // Reset mid-stall with flush asserted.
    drive(1, 0, 0, 2'b10, 1, 32'h0, 32'h0000_0803, 32'h0);
    cycle();
    check("rst_pc",     imem_addr, 32'h0);
    check("rst_valid2", IF_ID_Valid, 1'b0);
    check("rst_stall",  stall_cnt, 8'd0);
    check("rst_flush",  flush_cnt, 8'd0);
    check("rst_mis",    misalign_err, 1'b0);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      logic [31:0] bt, jt, jrt;
      bt  = $urandom; jt = $urandom; jrt = $urandom;
      if ($urandom_range(0, 3) != 0) begin
        bt[1:0] = 2'b00; jt[1:0] = 2'b00; jrt[1:0] = 2'b00;
      end
      drive(($urandom_range(0, 99) == 0),
            ($urandom_range(0, 4) != 0),
            ($urandom_range(0, 4) != 0),
            2'($urandom_range(0, 3)),
            ($urandom_range(0, 3) == 0),
            bt, jt, jrt);
      cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
